// File: rtl/usb_clkgen.sv
// ============================================================================
// Module      : usb_clkgen
// Description : Multi-channel NCO clock / tick-enable generator with a settle
//               lock flag. Optional sync input: define USB_CLKGEN_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module usb_clkgen #(
    parameter int          CHANNELS    = 4,
    parameter int          ACC_W       = 32,
    parameter int unsigned DEFAULT_INC = 100663296,
    parameter int          LOCK_CYCLES = 1024,
    localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] outclk,
    output logic [CHANNELS-1:0] tick,
    output logic                locked
`ifdef USB_CLKGEN_SYNC_EN
    ,
    input  logic                sync
`endif
);

    localparam int               c_CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_CYCLES - 1);
    localparam logic [0:0]       c_SETTLE   = 1'b0;
    localparam logic [0:0]       c_LOCKED   = 1'b1;

    logic               w_xfer;
    logic               w_chan_ok;
    logic               w_wr_ok;
    logic               w_sync;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_err;

`ifdef USB_CLKGEN_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // No back-pressure: ready simply mirrors reset.
    assign cfg_ready = ~rst;
    assign w_xfer    = cfg_valid & cfg_ready;
    assign w_wr_ok   = w_xfer & w_chan_ok;
    assign cfg_err   = r_err;

    // Channel range check by enumeration so it stays valid for any CHANNELS.
    always_comb begin
        w_chan_ok = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CH_W'(i)) begin
                w_chan_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_chan_ok;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= c_SETTLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_wr_ok) begin
            w_state_nxt = c_SETTLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_SETTLE: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_LOCKED;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_LOCKED;
                end
            endcase
        end
    end

    always_comb begin
        locked = (r_state == c_LOCKED);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [ACC_W-1:0] r_inc;
        logic [ACC_W-1:0] r_acc;
        logic             r_msb_prev;
        logic             r_tick;
        logic             w_wr;

        assign w_wr = w_wr_ok && (cfg_chan == CH_W'(g));

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_inc      <= ACC_W'(DEFAULT_INC);
                r_acc      <= '0;
                r_msb_prev <= 1'b0;
                r_tick     <= 1'b0;
            end else begin
                r_tick <= r_acc[ACC_W-1] & ~r_msb_prev;
                if (w_wr) begin
                    r_inc <= cfg_inc;
                end
                // A clear restarts the phase so the first add happens next edge.
                if (w_wr || w_sync) begin
                    r_acc      <= '0;
                    r_msb_prev <= 1'b0;
                end else begin
                    r_acc      <= r_acc + r_inc;
                    r_msb_prev <= r_acc[ACC_W-1];
                end
            end
        end

        assign outclk[g] = r_acc[ACC_W-1];
        assign tick[g]   = r_tick;
    end

endmodule

`default_nettype wire
